// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with mid-bit sampling, false-start
// rejection, configurable data/stop bits, stop-bit framing check and a
// valid/ready holding register with overrun reporting.
//
// Optional feature macro: UART_RX_PARITY_EN (adds one parity bit after the
// data bits; PARITY_ODD selects odd parity). Without it parity_err is 0.
//
// Ports:
//   clk        system clock
//   srst_n     asynchronous active-low reset
//   rx         serial line, idle high, asynchronous to clk
//   rx_ready   consumer accepts the held word
//   rx_valid   holding register contains a word
//   rx_data    received word (LSB first on the line)
//   frame_err  stop-bit error flag for the current rx_data
//   overrun    one-cycle pulse: a completed word was dropped
//   parity_err parity error flag for the current rx_data
module uart_rx_param #(
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned PARITY_ODD   = 0
) (
   input  logic                 clk,
   input  logic                 srst_n,
   input  logic                 rx,
   input  logic                 rx_ready,
   output logic                 rx_valid,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 parity_err
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam int unsigned BW = 4;
   localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;
   localparam logic [2:0] S_BREAK  = 3'd5;

   // Elaboration-time parameter legality check
   if (DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0 ||
       STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_param_check
      $error("uart_rx_param: illegal parameter value");
   end

   logic                 rx_meta, rx_s, rx_prev;
   logic [2:0]           state_q, state_d;
   logic [CW-1:0]        baud_cnt;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 ferr_pend;

   logic start_edge_c, tick_c, last_data_c, last_stop_c, ferr_c, commit_c, perr_c;

   // Two-stage synchroniser plus previous-sample register for edge detect;
   // all reset high so reset release never looks like a start edge
   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   assign start_edge_c = !rx_s && rx_prev;
   assign tick_c       = (baud_cnt == '0);
   assign last_data_c  = (bit_cnt == BW'(DATA_BITS - 1));
   assign last_stop_c  = (bit_cnt == BW'(STOP_BITS - 1));
   assign ferr_c       = ferr_pend | ~rx_s;
   assign commit_c     = (state_q == S_STOP) && tick_c && last_stop_c;

   // State register
   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start_edge_c) state_d = S_START;
         S_START:  if (tick_c) state_d = rx_s ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
         S_DATA:   if (tick_c && last_data_c) state_d = S_PARITY;
`else
         S_DATA:   if (tick_c && last_data_c) state_d = S_STOP;
`endif
         S_PARITY: if (tick_c) state_d = S_STOP;
         S_STOP:   if (tick_c && last_stop_c) state_d = ferr_c ? S_BREAK : S_IDLE;
         S_BREAK:  if (rx_s) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

`ifdef UART_RX_PARITY_EN
   logic par_bit;

   // Received parity bit, captured mid-bit
   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n)                            par_bit <= 1'b0;
      else if (state_q == S_PARITY && tick_c) par_bit <= rx_s;
   end

   assign perr_c = ((^shreg) ^ 1'(PARITY_ODD)) != par_bit;
`else
   assign perr_c = 1'b0;
`endif

   // Baud counter, bit counter, shift register and pending framing error
   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n) begin
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         ferr_pend <= 1'b0;
      end else begin
         if (state_q == S_IDLE) begin
            if (start_edge_c) baud_cnt <= HALF_LOAD;
         end else if (tick_c) begin
            baud_cnt <= FULL_LOAD;
         end else begin
            baud_cnt <= baud_cnt - CW'(1);
         end

         if (tick_c) begin
            case (state_q)
               S_START: begin
                  bit_cnt   <= '0;
                  ferr_pend <= 1'b0;
               end
               S_DATA: begin
                  shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                  bit_cnt <= last_data_c ? '0 : bit_cnt + BW'(1);
               end
               S_STOP: begin
                  bit_cnt   <= bit_cnt + BW'(1);
                  ferr_pend <= ferr_c;
               end
               default: ;
            endcase
         end
      end
   end

   // Holding register: a commit loads unless an unaccepted word is held
   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n) begin
         rx_valid   <= 1'b0;
         rx_data    <= '0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (commit_c) begin
            if (!rx_valid || rx_ready) begin
               rx_valid   <= 1'b1;
               rx_data    <= shreg;
               frame_err  <= ferr_c;
               parity_err <= perr_c;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule
